// File: rtl/instruction_prefetch_unit_pkg.sv
// Shared definitions for the instruction prefetch unit: fetch FSM state
// encodings, instruction alignment mask and a saturating-add helper.
package instruction_prefetch_unit_pkg;

    localparam int PF_STATE_WIDTH = 2;

    typedef enum logic [PF_STATE_WIDTH-1:0] {
        PF_IDLE = 2'd0,
        PF_ADDR = 2'd1,
        PF_DATA = 2'd2
    } pf_state_e;

    // Instructions are word aligned; the low two PC bits are always zero.
    localparam logic [31:0] INSTR_ALIGN_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? '1 : sum[31:0];
    endfunction

endpackage

// File: rtl/instruction_prefetch_unit_prefetch_fifo.sv
// Synchronous show-ahead FIFO holding {PC, instruction} pairs. The head entry
// is visible combinationally; flush empties it and overrides push/pop.
module prefetch_fifo #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       i_Clock,
    input  logic                       w_Reset,
    input  logic                       i_Push,
    input  logic [XLEN-1:0]            i_Push_PC,
    input  logic [XLEN-1:0]            i_Push_Instr,
    input  logic                       i_Pop,
    input  logic                       i_Flush,
    output logic [XLEN-1:0]            o_Head_PC,
    output logic [XLEN-1:0]            o_Head_Instr,
    output logic [$clog2(DEPTH):0]     o_Count,
    output logic                       o_Full,
    output logic                       o_Empty
);
    import instruction_prefetch_unit_pkg::*;

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [XLEN-1:0]  pc_mem_q    [DEPTH];
    logic [XLEN-1:0]  instr_mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign o_Count      = count_q;
    assign o_Empty      = (count_q == '0);
    assign o_Full       = (count_q == (PTR_W+1)'(DEPTH));
    // Empty FIFO presents zeros rather than stale storage.
    assign o_Head_PC    = o_Empty ? '0 : pc_mem_q[rd_ptr_q];
    assign o_Head_Instr = o_Empty ? '0 : instr_mem_q[rd_ptr_q];

    // Next pointer/count state; flush wins over push and pop.
    always_comb begin
        do_push  = i_Push && !i_Flush;
        do_pop   = i_Pop && !o_Empty && !i_Flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge i_Clock) begin
        if (w_Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only observable while counted as valid.
    always_ff @(posedge i_Clock) begin
        if (do_push) begin
            pc_mem_q[wr_ptr_q]    <= i_Push_PC;
            instr_mem_q[wr_ptr_q] <= i_Push_Instr;
        end
    end

endmodule

// File: rtl/instruction_prefetch_unit.sv
// Instruction prefetch unit: issues sequential AXI4-Lite reads (one in
// flight), buffers {PC, instruction} in a show-ahead FIFO for S1 and
// restarts on redirect, discarding any response already in flight.
// Optional: define PREFETCH_PERF_COUNTERS_EN for fetch/discard counters.
module instruction_prefetch_unit
    import instruction_prefetch_unit_pkg::*;
#(
    parameter int unsigned      XLEN     = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic                i_Clock,
    input  logic                w_Reset,
    input  logic                i_Enable,
    input  logic                i_Redirect,
    input  logic [XLEN-1:0]     i_Redirect_PC,
    input  logic                i_Instruction_Ready,
    output logic [XLEN-1:0]     o_Instruction,
    output logic [XLEN-1:0]     o_Instruction_PC,
    output logic                o_Instruction_Valid,
    output logic [XLEN-1:0]     s_axil_araddr,
    output logic                s_axil_arvalid,
    input  logic                s_axil_arready,
    input  logic [XLEN-1:0]     s_axil_rdata,
    input  logic                s_axil_rvalid,
    output logic                s_axil_rready,
    output logic [XLEN-1:0]     s_axil_awaddr,
    output logic                s_axil_awvalid,
    input  logic                s_axil_awready,
    output logic [XLEN-1:0]     s_axil_wdata,
    output logic [XLEN/8-1:0]   s_axil_wstrb,
    output logic                s_axil_wvalid,
    input  logic                s_axil_wready,
    input  logic                s_axil_bvalid,
    input  logic [1:0]          s_axil_bresp,
    output logic                s_axil_bready
`ifdef PREFETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]         o_Fetch_Count,
    output logic [31:0]         o_Discard_Count
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(~INSTR_ALIGN_MASK);

    pf_state_e          state_q, state_d;
    logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]    araddr_q, araddr_d;
    logic               discard_q, discard_d;
    logic               fifo_push;
    logic               fifo_pop;
    logic               resp_drop;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               unused_inputs;

    // Read-only master: write channels are parked.
    assign s_axil_awaddr  = '0;
    assign s_axil_awvalid = 1'b0;
    assign s_axil_wdata   = '0;
    assign s_axil_wstrb   = '0;
    assign s_axil_wvalid  = 1'b0;
    assign s_axil_bready  = 1'b0;
    assign unused_inputs  = ^{s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_bresp, fifo_full};

    assign s_axil_arvalid      = (state_q == PF_ADDR);
    assign s_axil_araddr       = araddr_q;
    assign s_axil_rready       = (state_q == PF_DATA);
    assign o_Instruction_Valid = !fifo_empty;
    assign fifo_pop            = o_Instruction_Valid && i_Instruction_Ready;

    prefetch_fifo #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_Clock      (i_Clock),
        .w_Reset      (w_Reset),
        .i_Push       (fifo_push),
        .i_Push_PC    (fetch_pc_q),
        .i_Push_Instr (s_axil_rdata),
        .i_Pop        (fifo_pop),
        .i_Flush      (i_Redirect),
        .o_Head_PC    (o_Instruction_PC),
        .o_Head_Instr (o_Instruction),
        .o_Count      (fifo_count),
        .o_Full       (fifo_full),
        .o_Empty      (fifo_empty)
    );

    // Fetch FSM next state, AXI address capture and discard bookkeeping.
    // The issued address lives in araddr_q so a redirect during ADDR can move
    // fetch_pc without disturbing the address held on the bus.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        araddr_d   = araddr_q;
        discard_d  = discard_q;
        fifo_push  = 1'b0;
        resp_drop  = 1'b0;
        case (state_q)
            PF_IDLE: begin
                if (i_Enable && !i_Redirect && (fifo_count < CNT_W'(DEPTH))) begin
                    state_d  = PF_ADDR;
                    araddr_d = fetch_pc_q;
                end
            end
            PF_ADDR: begin
                if (s_axil_arready) state_d = PF_DATA;
            end
            PF_DATA: begin
                if (s_axil_rvalid) begin
                    state_d   = PF_IDLE;
                    discard_d = 1'b0;
                    if (discard_q || i_Redirect) begin
                        resp_drop = 1'b1;
                    end else begin
                        fifo_push  = 1'b1;
                        fetch_pc_d = fetch_pc_q + XLEN'(4);
                    end
                end
            end
            default: state_d = PF_IDLE;
        endcase
        if (i_Redirect) begin
            fetch_pc_d = i_Redirect_PC & ALIGN_MASK;
            if ((state_q == PF_ADDR) || ((state_q == PF_DATA) && !s_axil_rvalid))
                discard_d = 1'b1;
        end
    end

    // Fetch FSM and address registers.
    always_ff @(posedge i_Clock) begin
        if (w_Reset) begin
            state_q    <= PF_IDLE;
            fetch_pc_q <= RESET_PC;
            araddr_q   <= '0;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            araddr_q   <= araddr_d;
            discard_q  <= discard_d;
        end
    end

`ifdef PREFETCH_PERF_COUNTERS_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] discard_cnt_q, discard_cnt_d;

    assign o_Fetch_Count   = fetch_cnt_q;
    assign o_Discard_Count = discard_cnt_q;

    // Saturating counts of pushed responses and of dropped/flushed work.
    always_comb begin
        fetch_cnt_d   = sat_add32(fetch_cnt_q, {31'd0, fifo_push});
        discard_cnt_d = sat_add32(discard_cnt_q,
                                  {31'd0, resp_drop} + (i_Redirect ? 32'(fifo_count) : 32'd0));
    end

    // Counter registers.
    always_ff @(posedge i_Clock) begin
        if (w_Reset) begin
            fetch_cnt_q   <= '0;
            discard_cnt_q <= '0;
        end else begin
            fetch_cnt_q   <= fetch_cnt_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end
`else
    logic unused_perf;
    assign unused_perf = resp_drop;
`endif

endmodule
